// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
// Arbiter FSM states, load/store funct3 encodings and the default bus timeout.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/replication, misalign detect, load extraction.
// Latency: purely combinational.
// Backpressure: none, this block has no handshake.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    output logic        req_err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    logic [31:0] ld_shifted;

    assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = req_wdata;
        req_err  = 1'b0;
        case (req_funct3)
            LS_B, LS_BU: begin
                st_wstrb = 4'b0001 << req_off;
                st_wdata = {4{req_wdata[7:0]}};
            end
            LS_H, LS_HU: begin
                st_wstrb = 4'b0011 << req_off;
                st_wdata = {2{req_wdata[15:0]}};
                req_err  = req_off[0];
            end
            LS_W: begin
                st_wstrb = 4'b1111;
                req_err  = (req_off != 2'b00);
            end
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        ld_result = ld_rdata;
        case (ld_funct3)
            LS_B:  ld_result = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LS_BU: ld_result = {24'h000000, ld_shifted[7:0]};
            LS_H:  ld_result = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            LS_HU: ld_result = {16'h0000, ld_shifted[15:0]};
            default: ld_result = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data wins, stall holds the pipeline.
// Latency: 3 cycles request-to-done with a 1-cycle ack, 2 for a misaligned/bad access.
// Backpressure: mem_req held until mem_ack or TIMEOUT cycles; requesters held via stall.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_read_en,
    input  logic        dm_write_en,
    input  logic [2:0]  dm_funct3,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        is_data_q, err_q, flush_q, we_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;

    logic        dm_req, req_err, timeout_hit;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, ld_result;

    assign dm_req      = dm_read_en | dm_write_en;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    lsu_align u_align (
        .req_funct3 (dm_funct3),
        .req_off    (dm_addr[1:0]),
        .req_wdata  (dm_wdata),
        .st_wstrb   (st_wstrb),
        .st_wdata   (st_wdata),
        .req_err    (req_err),
        .ld_funct3  (funct3_q),
        .ld_off     (off_q),
        .ld_rdata   (rdata_q),
        .ld_result  (ld_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dm_req)
                    state_d = req_err ? ST_RESP : ST_DATA;
                else if (if_req && !if_flush)
                    state_d = ST_FETCH;
            end
            ST_DATA, ST_FETCH: begin
                if (mem_ack || timeout_hit)
                    state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_data_q <= 1'b0;
            err_q     <= 1'b0;
            flush_q   <= 1'b0;
            we_q      <= 1'b0;
            off_q     <= 2'b00;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (dm_req) begin
                        is_data_q <= 1'b1;
                        err_q     <= req_err;
                        flush_q   <= 1'b0;
                        we_q      <= dm_write_en;
                        off_q     <= dm_addr[1:0];
                        funct3_q  <= dm_funct3;
                        addr_q    <= dm_addr & 32'hFFFF_FFFC;
                        wdata_q   <= dm_write_en ? st_wdata : 32'h0;
                        wstrb_q   <= dm_write_en ? st_wstrb : 4'b0000;
                        cnt_q     <= '0;
                    end else if (if_req && !if_flush) begin
                        is_data_q <= 1'b0;
                        err_q     <= 1'b0;
                        flush_q   <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= if_addr & 32'hFFFF_FFFC;
                        wdata_q   <= 32'h0;
                        wstrb_q   <= 4'b0000;
                        cnt_q     <= '0;
                    end
                end
                ST_DATA, ST_FETCH: begin
                    // An ack in the final allowed cycle beats the timeout.
                    if (mem_ack)
                        rdata_q <= mem_rdata;
                    else if (timeout_hit)
                        err_q <= 1'b1;
                    else
                        cnt_q <= cnt_q + CW'(1);
                    if (state_q == ST_FETCH && if_flush)
                        flush_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state_q == ST_DATA) || (state_q == ST_FETCH);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    assign dm_done  = (state_q == ST_RESP) & is_data_q;
    assign dm_err   = dm_done & err_q;
    assign dm_rdata = dm_done ? ld_result : 32'h0;
    assign if_valid = (state_q == ST_RESP) & ~is_data_q & ~err_q & ~flush_q;
    assign if_rdata = if_valid ? rdata_q : 32'h0;

    assign stall = (dm_req & ~dm_done) | (if_req & ~if_valid & ~if_flush);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4 and hand-computed expectations.
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    logic        clk, rst_n;
    logic        if_req, if_flush;
    logic [31:0] if_addr, if_rdata;
    logic        if_valid;
    logic        dm_read_en, dm_write_en;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_done, dm_err, stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we, obs_done, obs_err, obs_stall, obs_stall_ok;
    int          obs_cycles;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_read_en(dm_read_en), .dm_write_en(dm_write_en), .dm_funct3(dm_funct3),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_done(dm_done), .dm_err(dm_err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one load/store; ack is given in the DATA cycle numbered ack_at (0-based).
    task automatic data_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        dm_read_en = !we; dm_write_en = we; dm_funct3 = f3; dm_addr = addr; dm_wdata = wd;
        obs_cycles = 0; obs_stall_ok = 1'b1;
        obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_we = 1'b0;
        step();
        while (mem_req && obs_cycles < 20) begin
            obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
            if (!stall) obs_stall_ok = 1'b0;
            if (obs_cycles == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
            step();
            mem_ack = 1'b0;
            obs_cycles++;
        end
        obs_done = dm_done; obs_err = dm_err; obs_rdata = dm_rdata; obs_stall = stall;
        step();
        dm_read_en = 1'b0; dm_write_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; if_flush = 0; dm_read_en = 0; dm_write_en = 0;
        dm_funct3 = 0; dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_rdata = 0;
        step(); step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if ({dm_done, dm_err, if_valid, mem_we} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {dm_done, dm_err, if_valid, mem_we}); end
        checks++; if (mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_buses addr %h strb %h rdata %h want 0", mem_addr, mem_wstrb, dm_rdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        data_access(1'b0, LS_W, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 00000100", obs_addr); end
        checks++; if (obs_wstrb !== 4'h0 || obs_we !== 1'b0) begin errors++; $display("FAIL lw_strb_we got %h/%b want 0/0", obs_wstrb, obs_we); end
        checks++; if (obs_cycles !== 3) begin errors++; $display("FAIL lw_req_cycles got %0d want 3", obs_cycles); end
        checks++; if (obs_done !== 1'b1 || obs_err !== 1'b0) begin errors++; $display("FAIL lw_done got done %b err %b want 1 0", obs_done, obs_err); end
        checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", obs_rdata); end
        checks++; if (obs_stall_ok !== 1'b1 || obs_stall !== 1'b0) begin errors++; $display("FAIL lw_stall during %b done %b want 1 0", obs_stall_ok, obs_stall); end
        checks++; if (dm_done !== 1'b0) begin errors++; $display("FAIL lw_done_pulse got %b want 0", dm_done); end
    endtask

    task automatic test_bytes_halves();
        data_access(1'b1, LS_B, 32'h203, 32'h0000005A, 32'h0, 0);
        checks++; if (obs_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_strb got %b want 1000", obs_wstrb); end
        checks++; if (obs_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wdata got %h want 5a5a5a5a", obs_wdata); end
        checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h200) begin errors++; $display("FAIL sb_we_addr got %b %h want 1 00000200", obs_we, obs_addr); end
        data_access(1'b0, LS_B, 32'h203, 32'h0, 32'h80FFFFFF, 0);
        checks++; if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", obs_rdata); end
        data_access(1'b0, LS_BU, 32'h203, 32'h0, 32'h80FFFFFF, 0);
        checks++; if (obs_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h want 00000080", obs_rdata); end
        data_access(1'b0, LS_H, 32'h102, 32'h0, 32'h80011234, 1);
        checks++; if (obs_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata got %h want ffff8001", obs_rdata); end
        data_access(1'b0, LS_HU, 32'h100, 32'h0, 32'h1234F00D, 0);
        checks++; if (obs_rdata !== 32'h0000F00D) begin errors++; $display("FAIL lhu_rdata got %h want 0000f00d", obs_rdata); end
        data_access(1'b1, LS_H, 32'h102, 32'h1234ABCD, 32'h0, 0);
        checks++; if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_lanes got %b %h want 1100 abcdabcd", obs_wstrb, obs_wdata); end
        data_access(1'b1, LS_W, 32'h204, 32'hCAFEF00D, 32'h0, 0);
        checks++; if (obs_wstrb !== 4'b1111 || obs_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_lanes got %b %h want 1111 cafef00d", obs_wstrb, obs_wdata); end
    endtask

    task automatic test_misalign();
        data_access(1'b0, LS_H, 32'h101, 32'h0, 32'h0, 0);
        checks++; if (obs_cycles !== 0) begin errors++; $display("FAIL lh_mis_req got %0d bus cycles want 0", obs_cycles); end
        checks++; if (obs_done !== 1'b1 || obs_err !== 1'b1) begin errors++; $display("FAIL lh_mis_err got done %b err %b want 1 1", obs_done, obs_err); end
        data_access(1'b1, LS_W, 32'h102, 32'h0, 32'h0, 0);
        checks++; if (obs_cycles !== 0 || obs_err !== 1'b1) begin errors++; $display("FAIL sw_mis got %0d cycles err %b want 0 1", obs_cycles, obs_err); end
        data_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        checks++; if (obs_cycles !== 0 || obs_err !== 1'b1) begin errors++; $display("FAIL bad_f3 got %0d cycles err %b want 0 1", obs_cycles, obs_err); end
    endtask

    task automatic test_timeout();
        data_access(1'b0, LS_W, 32'h300, 32'h0, 32'h0, 99);
        checks++; if (obs_cycles !== 4) begin errors++; $display("FAIL to_req_cycles got %0d want 4", obs_cycles); end
        checks++; if (obs_done !== 1'b1 || obs_err !== 1'b1) begin errors++; $display("FAIL to_err got done %b err %b want 1 1", obs_done, obs_err); end
        data_access(1'b0, LS_W, 32'h300, 32'h0, 32'h600DF00D, 3);
        checks++; if (obs_cycles !== 4 || obs_err !== 1'b0 || obs_done !== 1'b1) begin errors++; $display("FAIL to_ack_edge got %0d cycles err %b done %b want 4 0 1", obs_cycles, obs_err, obs_done); end
        checks++; if (obs_rdata !== 32'h600DF00D) begin errors++; $display("FAIL to_ack_rdata got %h want 600df00d", obs_rdata); end
        // Fetch timeout: no if_valid, then the fetch reissues.
        if_req = 1'b1; if_addr = 32'h80;
        step();
        obs_cycles = 0;
        while (mem_req && obs_cycles < 20) begin step(); obs_cycles++; end
        checks++; if (obs_cycles !== 4 || if_valid !== 1'b0) begin errors++; $display("FAIL fetch_to got %0d cycles valid %b want 4 0", obs_cycles, if_valid); end
        step(); step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin errors++; $display("FAIL fetch_reissue got req %b addr %h want 1 00000080", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h00000013;
        step();
        mem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00000013) begin errors++; $display("FAIL fetch_retry got valid %b data %h want 1 00000013", if_valid, if_rdata); end
        step();
        if_req = 1'b0;
        step();
    endtask

    task automatic test_priority();
        int t;
        if_req = 1'b1; if_addr = 32'h400;
        dm_read_en = 1'b1; dm_funct3 = LS_W; dm_addr = 32'h100;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL prio_data_first got req %b addr %h want 1 00000100", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        step();
        mem_ack = 1'b0;
        checks++; if (dm_done !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL prio_done got done %b valid %b want 1 0", dm_done, if_valid); end
        step();
        dm_read_en = 1'b0;
        t = 1;
        while (!mem_req && t < 10) begin step(); t++; end
        checks++; if (mem_addr !== 32'h400 || mem_we !== 1'b0) begin errors++; $display("FAIL prio_fetch_addr got %h we %b want 00000400 0", mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'h00100093;
        step(); t++;
        mem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00100093) begin errors++; $display("FAIL prio_fetch_valid got %b %h want 1 00100093", if_valid, if_rdata); end
        checks++; if (t < 3 || t >= 10) begin errors++; $display("FAIL prio_gap got %0d cycles want >=3", t); end
        step();
        if_req = 1'b0;
        step();
    endtask

    task automatic test_flush_and_reset();
        // Flush in IDLE: the fetch never reaches the bus.
        if_req = 1'b1; if_addr = 32'h500; if_flush = 1'b1;
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_idle got req %b want 0", mem_req); end
        if_flush = 1'b0;
        step();
        checks++; if (mem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL flush_fetch_start got req %b stall %b want 1 1", mem_req, stall); end
        if_flush = 1'b1; if_req = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        step();
        if_flush = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL flush_bus_holds got %b want 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0;
        checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL flush_suppress got valid %b req %b want 0 0", if_valid, mem_req); end
        step();
        // Reset in the middle of a data access.
        dm_read_en = 1'b1; dm_funct3 = LS_W; dm_addr = 32'h600;
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_start got %b want 1", mem_req); end
        rst_n = 1'b0; dm_read_en = 1'b0;
        step();
        checks++; if ({mem_req, mem_we, dm_done, dm_err, if_valid, stall} !== 6'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs got %b addr %h want 0", {mem_req, mem_we, dm_done, dm_err, if_valid, stall}, mem_addr); end
        rst_n = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ack = 1'b0;
        checks++; if ({mem_req, dm_done, if_valid} !== 3'b0) begin errors++; $display("FAIL stray_ack got %b want 000", {mem_req, dm_done, if_valid}); end
        step();
        checks++; if ({mem_req, dm_done, if_valid} !== 3'b0) begin errors++; $display("FAIL stray_ack_late got %b want 000", {mem_req, dm_done, if_valid}); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_bytes_halves();
        test_misalign();
        test_timeout();
        test_priority();
        test_flush_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch and the load/store path of the 3-stage pipeline. Data accesses take priority over fetches. The block sequences each access through a req/ack handshake, applies byte-lane alignment and load extension from funct3, and drives `stall` so the pipeline holds PC and stage registers until its access completes. It sits between the fetch/execute stages and the memory bus, fed by the decoder's `read_en`/`write_en`.

## Interface
- `TIMEOUT`, 255: maximum cycles with `mem_req` high and no `mem_ack` before aborting.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request; held until `if_valid`.
- `if_addr` in 32: fetch address, word-aligned.
- `if_flush` in 1: drop the current fetch (branch/jump taken).
- `if_rdata` out 32: instruction word, valid with `if_valid`.
- `if_valid` out 1: one-cycle pulse, fetch done.
- `dm_read_en`, `dm_write_en` in 1 each: load/store request; held until `dm_done`; never both high.
- `dm_funct3` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `dm_addr` in 32: byte address.
- `dm_wdata` in 32: store data, LSB-justified.
- `dm_rdata` out 32: extended load result, valid with `dm_done`.
- `dm_done` out 1: one-cycle pulse, data access finished.
- `dm_err` out 1: pulses with `dm_done` on misalign, bad funct3 or timeout.
- `stall` out 1: hold PC and pipeline registers.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word address (`[1:0]` = 0).
- `mem_wdata` out 32: lane-shifted store data.
- `mem_wstrb` out 4: byte enables.
- `mem_ack` in 1: bus completion; `mem_rdata` valid in the same cycle.
- `mem_rdata` in 32: bus read data.

## Operation
- FSM states: IDLE, DATA, FETCH, RESP.
- IDLE transitions:
  - Data request → DATA. Data wins over a simultaneous fetch.
  - Otherwise fetch request → FETCH.
  - Misaligned or invalid-funct3 data request → RESP with err, no bus access. Misaligned means H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
- DATA/FETCH:
  - `mem_req`=1; addr/we/wdata/wstrb are registered at entry and stay stable until ack.
  - On `mem_ack` → RESP, capturing `mem_rdata`.
  - Timeout counter reaching `TIMEOUT` → RESP with err. `mem_req` drops on the same edge.
- RESP: pulse `dm_done`/`dm_err` or `if_valid` for one cycle, then → IDLE.
- Store strobes:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
  - `mem_wdata` is `dm_wdata` replicated across lanes: B → {4{b}}, H → {2{h}}.
- Load extraction: select the byte/half at `addr[1:0]`; sign-extend for B/H, zero-extend for BU/HU; W is passed through.
- Flush:
  - In IDLE, `if_flush` cancels a pending fetch before it is issued.
  - In FETCH, the bus access completes, but RESP suppresses `if_valid`.
  - Flush has no effect on data accesses.
- A fetch timeout gives RESP with `if_valid` suppressed; the fetch re-issues on the next IDLE while `if_req` stays high.
- `stall` (combinational) = (`dm_read_en`|`dm_write_en`) & ~`dm_done` | `if_req` & ~`if_valid` & ~`if_flush`.

## Timing
- Reset values: state IDLE; all outputs 0, including `stall`; timeout counter 0.
- Reset mid-access: `mem_req` drops at the reset edge; a later `mem_ack` seen in IDLE is ignored.
- Request sampled in IDLE at edge N → `mem_req` high from N+1.
- `mem_ack` at edge M → done/valid pulse in cycle M+1 → IDLE at M+2.
- Minimum latency: 3 cycles request-to-done with a 1-cycle ack. A misaligned access errors in 2.
- A fetch waiting behind a data access issues at the first IDLE after that access's RESP.
- Timeout counter:
  - Cleared on entry to DATA/FETCH; 8 bits wide for the default, sized `$clog2(TIMEOUT+1)`.
  - Compares before increment.
  - An ack arriving in the same cycle as the timeout wins: no error.

## Structure
- Shared package `riscv_pkg` holds:
  - `arb_state_t` enum.
  - funct3 constants `LS_B/LS_H/LS_W/LS_BU/LS_HU`.
  - Default `TIMEOUT`.
- Sub-module `lsu_align` (combinational) contains strobe/wdata replication, load extraction and misalign detect. The top level contains the FSM, registers and counter.

## Test plan
- LW at 0x100, ack after 2 cycles with `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `wstrb`=0, `dm_rdata`=0xDEADBEEF, `dm_done` pulse; `stall` high throughout, low in the done cycle.
- SB at 0x203, `wdata`=0x5A → `wstrb`=4'b1000, `mem_wdata`=0x5A5A5A5A, `mem_we`=1; LB at 0x203 reading 0x80FFFFFF → `dm_rdata`=0xFFFFFF80; LBU gives 0x00000080.
- `if_req` and `dm_read_en` raised in the same cycle → data bus cycle first, then fetch; `if_valid` follows `dm_done` by ≥3 cycles.
- LH at 0x101 → no `mem_req`, `dm_done`+`dm_err` 2 cycles later.
- `mem_ack` held low with `TIMEOUT`=4 → `mem_req` drops after 4 cycles, `dm_err` pulses; ack at exactly cycle 4 → normal done with no error.
- `if_flush` asserted during FETCH → bus access completes, no `if_valid`; `rst_n` low mid-DATA → all outputs 0 next edge, a stray ack is ignored.
